// File: rtl/led_trail_pwm.sv
// Comet-trail LED driver: lit channels are solid, released channels fade out
// linearly through a shared free-running PWM counter.
module led_trail_pwm #(
   parameter int unsigned PWM_BITS   = 8,
   parameter int unsigned DECAY_DIV  = 16,
   parameter int unsigned DECAY_STEP = 32
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [3:0] diode_in,
   input  logic       trail_en,
   output logic [3:0] led_out
);

   localparam int unsigned N_CH  = 4;
   localparam int unsigned DIV_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

   localparam logic [PWM_BITS-1:0] FULL_SCALE = '1;
   localparam logic [PWM_BITS-1:0] STEP       = PWM_BITS'(DECAY_STEP);
   localparam logic [DIV_W-1:0]    DIV_LAST   = DIV_W'(DECAY_DIV - 1);

   logic [N_CH-1:0]     diode_q, diode_d;
   logic [DIV_W-1:0]    decay_cnt_q, decay_cnt_d;
   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [PWM_BITS-1:0] brightness_q [N_CH];
   logic [PWM_BITS-1:0] brightness_d [N_CH];
   logic [N_CH-1:0]     led_out_q, led_out_d;
   logic                tick;

   // Next-state: input capture, decay timer, PWM counter, brightness, output.
   always_comb begin
      diode_d     = diode_in;
      tick        = (decay_cnt_q == DIV_LAST);
      decay_cnt_d = tick ? '0 : decay_cnt_q + DIV_W'(1);
      pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);
      led_out_d   = '0;
      for (int i = 0; i < N_CH; i++) begin
         brightness_d[i] = brightness_q[i];
         // A lit channel reloads full scale even on a decay tick.
         if (diode_q[i]) begin
            brightness_d[i] = FULL_SCALE;
         end else if (tick) begin
            brightness_d[i] = (brightness_q[i] > STEP) ? brightness_q[i] - STEP : '0;
         end
         led_out_d[i] = diode_q[i] | (trail_en & (pwm_cnt_q < brightness_q[i]));
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         diode_q     <= '0;
         decay_cnt_q <= '0;
         pwm_cnt_q   <= '0;
         led_out_q   <= '0;
         for (int i = 0; i < N_CH; i++) begin
            brightness_q[i] <= '0;
         end
      end else begin
         diode_q     <= diode_d;
         decay_cnt_q <= decay_cnt_d;
         pwm_cnt_q   <= pwm_cnt_d;
         led_out_q   <= led_out_d;
         for (int i = 0; i < N_CH; i++) begin
            brightness_q[i] <= brightness_d[i];
         end
      end
   end

   assign led_out = led_out_q;

endmodule

// File: tb/tb_led_trail_pwm.sv
// Directed bench for led_trail_pwm: reset, bypass, fade, PWM duty, rotation.
module tb_led_trail_pwm;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [3:0] diode_in;
   logic       trail_en;
   logic [3:0] led_out;
   logic [3:0] led_out_slow;

   int errors = 0;
   int checks = 0;
   int ecnt   = 0;

   always #5 clock = ~clock;

   led_trail_pwm dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .diode_in (diode_in),
      .trail_en (trail_en),
      .led_out  (led_out)
   );

   // Slow decay variant so brightness holds at 127 across a full PWM period.
   led_trail_pwm #(.PWM_BITS(8), .DECAY_DIV(1024), .DECAY_STEP(128)) u_slow (
      .clock    (clock),
      .reset_n  (reset_n),
      .diode_in (diode_in),
      .trail_en (trail_en),
      .led_out  (led_out_slow)
   );

   task automatic step();
      @(posedge clock);
      #1;
      if (!reset_n) ecnt = 0;
      else          ecnt = ecnt + 1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      logic [3:0] pat [8];
      logic [7:0] hand [8];
      logic [7:0] vals [8];
      logic [7:0] b, prevb, expb;
      int bad, nvals, dt, hi, hi_fast, ch, pch, guard;
      bit done, found;

      pat  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      hand = '{8'd223, 8'd191, 8'd159, 8'd127, 8'd95, 8'd63, 8'd31, 8'd0};

      // Reset held for three edges with all inputs active.
      reset_n  = 1'b0;
      diode_in = 4'b1111;
      trail_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_led", 32'(led_out), 32'd0);
         check("rst_bright", 32'({dut.brightness_q[3], dut.brightness_q[2],
                                  dut.brightness_q[1], dut.brightness_q[0]}), 32'd0);
      end
      reset_n = 1'b1;
      step();
      check("rel_edge1", 32'(led_out), 32'd0);
      step();
      check("rel_edge2", 32'(led_out), 32'hF);

      // Bypass: output is the input delayed by two edges, no glow.
      trail_en = 1'b0;
      for (int k = 0; k < 8; k++) begin
         diode_in = pat[k];
         step();
         check("bypass", 32'(led_out), (k == 0) ? 32'hF : 32'(pat[k-1]));
      end

      // Hold channel 0 lit, then release and follow the fade.
      trail_en = 1'b1;
      diode_in = 4'b0001;
      bad = 0;
      for (int j = 0; j < 300; j++) begin
         step();
         if (j >= 1 && led_out[0] !== 1'b1) bad++;
      end
      check("hold_solid", 32'(bad), 32'd0);

      diode_in = 4'b0000;
      step();
      dt = ecnt;
      expb = 8'd255; prevb = 8'd255; nvals = 0; bad = 0; done = 1'b0; guard = 0;
      while (!done && guard < 200) begin
         step();
         guard++;
         if (ecnt % 16 == 0) expb = (expb > 8'd32) ? expb - 8'd32 : 8'd0;
         b = dut.brightness_q[0];
         if (b !== expb) bad++;
         if (b != prevb) begin
            if (nvals < 8) vals[nvals] = b;
            nvals++;
            prevb = b;
         end
         if (b == 8'd0) begin
            done = 1'b1;
            dt = ecnt - dt;
         end
      end
      check("fade_done", 32'(done), 32'd1);
      check("fade_track", 32'(bad), 32'd0);
      check("fade_steps", 32'(nvals), 32'd8);
      for (int v = 0; v < 8; v++) check("fade_val", 32'(vals[v]), 32'(hand[v]));
      check("fade_window", 32'(dt >= 113 && dt <= 128), 32'd1);
      step();
      step();
      bad = 0;
      for (int j = 0; j < 50; j++) begin
         step();
         if (led_out[0] !== 1'b0) bad++;
      end
      check("fade_off", 32'(bad), 32'd0);

      // PWM duty over one full period at constant brightness.
      found = 1'b0; guard = 0;
      while (!found && guard < 1200) begin
         step();
         guard++;
         if (u_slow.brightness_q[0] == 8'd127) found = 1'b1;
      end
      check("slow_reach127", 32'(found), 32'd1);
      hi = 0; hi_fast = 0;
      for (int j = 0; j < 256; j++) begin
         step();
         hi      = hi + int'(led_out_slow[0]);
         hi_fast = hi_fast + int'(led_out[0]);
      end
      check("duty_127", 32'(hi), 32'd127);
      check("duty_0", 32'(hi_fast), 32'd0);

      // Rotation with each capture edge one before a decay tick.
      guard = 0;
      while (ecnt % 16 != 14 && guard < 32) begin
         step();
         guard++;
      end
      for (int r = 0; r < 5; r++) begin
         ch  = r % 4;
         pch = (r + 3) % 4;
         diode_in = 4'(1 << ch);
         bad = 0;
         for (int k = 0; k < 64; k++) begin
            step();
            if (k == 1) check("reload_on_tick", 32'(dut.brightness_q[ch]), 32'd255);
            if (k >= 1 && led_out[ch] !== 1'b1) bad++;
            if (r > 0 && k == 32) check("trail_2ticks", 32'(dut.brightness_q[pch]), 32'd191);
            if (r > 0 && k == 40) check("trail_3ticks", 32'(dut.brightness_q[pch]), 32'd159);
         end
         check("rot_solid", 32'(bad), 32'd0);
      end

      // Reset in the middle of a channel-2 fade.
      diode_in = 4'b0100;
      for (int j = 0; j < 4; j++) step();
      diode_in = 4'b0000;
      found = 1'b0; guard = 0;
      while (!found && guard < 100) begin
         step();
         guard++;
         if (dut.brightness_q[2] == 8'd159) found = 1'b1;
      end
      check("midfade_reach159", 32'(found), 32'd1);
      reset_n = 1'b0;
      step();
      check("midrst_bright", 32'(dut.brightness_q[2]), 32'd0);
      check("midrst_led", 32'(led_out), 32'd0);
      reset_n = 1'b1;
      bad = 0;
      for (int j = 0; j < 300; j++) begin
         step();
         if (led_out !== 4'b0000) bad++;
      end
      check("no_glow", 32'(bad), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
